// File: rtl/rv32i_dbg_pkg.sv
// Shared definitions for the RV32I debug register-file dump path:
// FSM states, frame geometry and header layout.
package rv32i_dbg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StPc,
        StRegs
    } dump_state_e;

    localparam logic [15:0] HDR_TAG_DEFAULT = 16'hCAFE;
    localparam int unsigned FRAME_LEN       = 34;

    // Header word layout: {tag[15:0], seq[7:0], len[7:0]}
    localparam int unsigned HDR_TAG_LSB = 16;
    localparam int unsigned HDR_SEQ_LSB = 8;
    localparam int unsigned HDR_LEN_LSB = 0;

    function automatic logic [31:0] make_header(input logic [15:0] tag, input logic [7:0] seq);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_TAG_LSB +: 16] = tag;
        hdr[HDR_SEQ_LSB +: 8]  = seq;
        hdr[HDR_LEN_LSB +: 8]  = 8'(FRAME_LEN);
        return hdr;
    endfunction

endpackage

// File: rtl/regfile_dump_tx.sv
// Streams a snapshot frame (header, PC, x0..x31) of the CPU register file over a
// valid/ready link, reading registers through the second (debug) read port.
module regfile_dump_tx
    import rv32i_dbg_pkg::*;
#(
    parameter logic [15:0] HDR_TAG = HDR_TAG_DEFAULT,
    parameter int unsigned NREGS   = 32
) (
    input  logic        top_clk,
    input  logic        top_rst_n,
    input  logic        dump_req,
    input  logic [31:0] pc_in,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_data,
    output logic        tx_last,
    output logic        busy
);

    localparam logic [5:0] LastWord = 6'(NREGS + 1);

    dump_state_e state_q;
    logic [7:0]  seq_q;
    logic [5:0]  word_idx_q;
    logic [31:0] pc_q;
    logic        accept;

    assign accept = tx_valid & tx_ready;

    // Register index of word w is w[4:0]-2, so the next word's register is w[4:0]-1.
    // In PC this yields x0; after x31 it wraps back to 0.
    always_comb begin
        rf_raddr = '0;
        if (state_q == StPc || state_q == StRegs) begin
            rf_raddr = word_idx_q[4:0] - 5'd1;
        end
    end

    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            state_q    <= StIdle;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            seq_q      <= '0;
            word_idx_q <= '0;
            pc_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dump_req) begin
                        state_q    <= StHdr;
                        pc_q       <= pc_in;
                        tx_data    <= make_header(HDR_TAG, seq_q);
                        tx_valid   <= 1'b1;
                        tx_last    <= 1'b0;
                        busy       <= 1'b1;
                        word_idx_q <= '0;
                    end
                end
                StHdr: begin
                    if (accept) begin
                        state_q    <= StPc;
                        tx_data    <= pc_q;
                        word_idx_q <= 6'd1;
                    end
                end
                StPc: begin
                    if (accept) begin
                        state_q    <= StRegs;
                        tx_data    <= rf_rdata;
                        word_idx_q <= 6'd2;
                    end
                end
                StRegs: begin
                    if (accept) begin
                        if (word_idx_q == LastWord) begin
                            state_q    <= StIdle;
                            tx_valid   <= 1'b0;
                            tx_last    <= 1'b0;
                            busy       <= 1'b0;
                            seq_q      <= seq_q + 8'd1;
                            word_idx_q <= '0;
                        end else begin
                            tx_data    <= rf_rdata;
                            word_idx_q <= word_idx_q + 6'd1;
                            tx_last    <= (word_idx_q + 6'd1 == LastWord);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Self-checking bench for regfile_dump_tx: register file and frame contents modelled
// with plain arrays, randomized handshake and data.
module tb_regfile_dump_tx;

    logic        top_clk;
    logic        top_rst_n;
    logic        dump_req;
    logic [31:0] pc_in;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        tx_last;
    logic        busy;

    logic [31:0] rf [32];
    logic [7:0]  model_seq;
    logic [31:0] model_pc;
    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [31:0] hdr;

    regfile_dump_tx dut (
        .top_clk   (top_clk),
        .top_rst_n (top_rst_n),
        .dump_req  (dump_req),
        .pc_in     (pc_in),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .busy      (busy)
    );

    assign rf_rdata = rf[rf_raddr];

    initial top_clk = 1'b0;
    always #5 top_clk = ~top_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected frame word idx: header, PC snapshot, then register value at load time.
    function automatic logic [31:0] model_word(input int idx);
        if (idx == 0) return {16'hCAFE, model_seq, 8'd34};
        if (idx == 1) return model_pc;
        return rf[idx - 2];
    endfunction

    task automatic randomize_rf();
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
    endtask

    // Issues a request from IDLE; returns the header seen one edge later.
    task automatic start_frame(input logic [31:0] pc, output logic [31:0] h);
        pc_in    = pc;
        model_pc = pc;
        dump_req = 1'b1;
        tx_ready = 1'b0;
        @(posedge top_clk); #1;
        dump_req = 1'b0;
        pc_in    = $urandom;
        check("req_valid", 32'(tx_valid), 32'd1);
        check("req_busy", 32'(busy), 32'd1);
        check("req_hdr", tx_data, model_word(0));
        check("hdr_raddr", 32'(rf_raddr), 32'd0);
        h = tx_data;
    endtask

    // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic collect(input int mode, input bit pulse, input bit poke, output int cycles);
        int          idx;
        int          guard;
        bit          stalled;
        logic [31:0] held_d;
        logic        held_l;
        logic        v, l, r;
        logic [31:0] d;
        logic [3:0]  pat;
        pat     = 4'b1001;
        idx     = 0;
        guard   = 0;
        stalled = 0;
        cycles  = 0;
        while (idx < 34 && guard < 400) begin
            if (stalled) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", tx_data, held_d);
                check("stall_last", 32'(tx_last), 32'(held_l));
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = pat[3 - (cycles % 4)];
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            dump_req = pulse && (idx == 3 || idx == 33);
            if (poke && idx == 3) rf[20] = $urandom;
            v = tx_valid;
            d = tx_data;
            l = tx_last;
            r = tx_ready;
            @(posedge top_clk); #1;
            cycles++;
            guard++;
            dump_req = 1'b0;
            if (v && r) begin
                check("word", d, model_word(idx));
                check("last", 32'(l), 32'(idx == 33));
                idx++;
                stalled = 0;
            end else if (v) begin
                stalled = 1;
                held_d  = d;
                held_l  = l;
            end
        end
        tx_ready = 1'b0;
        check("frame_words", 32'(idx), 32'd34);
        check("end_busy", 32'(busy), 32'd0);
        check("end_valid", 32'(tx_valid), 32'd0);
        model_seq = model_seq + 8'd1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        dump_req  = 1'b0;
        tx_ready  = 1'b0;
        pc_in     = '0;
        top_rst_n = 1'b0;
        model_seq = '0;
        model_pc  = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        #3;
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_last", 32'(tx_last), 32'd0);
        check("rst_data", tx_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_raddr", 32'(rf_raddr), 32'd0);
        @(posedge top_clk); #1;
        top_rst_n = 1'b1;

        // Directed frame with back-to-back accepts
        rf[5]  = 32'h0000_0055;
        rf[31] = 32'hDEAD_BEEF;
        start_frame(32'h0000_0040, hdr);
        check("hdr_seq0", hdr, 32'hCAFE_0022);
        collect(0, 1'b0, 1'b0, cyc);
        check("zero_bubble", 32'(cyc), 32'd34);

        // Stalled handshake pattern
        randomize_rf();
        start_frame($urandom, hdr);
        check("hdr_seq1", hdr, 32'hCAFE_0122);
        collect(1, 1'b0, 1'b0, cyc);

        // Random ready, register rewritten mid-frame before it is loaded
        randomize_rf();
        start_frame($urandom, hdr);
        check("hdr_seq2", hdr, 32'hCAFE_0222);
        collect(2, 1'b0, 1'b1, cyc);

        // Requests while busy and on the last-accept edge are ignored
        randomize_rf();
        start_frame($urandom, hdr);
        collect(0, 1'b1, 1'b0, cyc);
        repeat (3) begin
            @(posedge top_clk); #1;
            check("no_extra_valid", 32'(tx_valid), 32'd0);
            check("no_extra_busy", 32'(busy), 32'd0);
        end
        start_frame($urandom, hdr);
        check("hdr_seq4", hdr, 32'hCAFE_0422);
        collect(2, 1'b0, 1'b0, cyc);

        // Asynchronous reset mid-REGS with x10 held on the link
        randomize_rf();
        start_frame($urandom, hdr);
        tx_ready = 1'b1;
        repeat (12) begin
            @(posedge top_clk); #1;
        end
        tx_ready = 1'b0;
        check("pre_rst_x10", tx_data, rf[10]);
        @(posedge top_clk); #1;
        check("pre_rst_hold", tx_data, rf[10]);
        #2;
        top_rst_n = 1'b0;
        #1;
        check("async_valid", 32'(tx_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_data", tx_data, 32'd0);
        check("async_raddr", 32'(rf_raddr), 32'd0);
        tx_ready = 1'b1;
        repeat (3) begin
            @(posedge top_clk); #1;
            check("rst_hold_valid", 32'(tx_valid), 32'd0);
        end
        top_rst_n = 1'b1;
        tx_ready  = 1'b0;
        model_seq = '0;
        start_frame($urandom, hdr);
        check("hdr_after_rst", hdr, 32'hCAFE_0022);
        collect(2, 1'b0, 1'b0, cyc);

        // 255 more frames complete 256 since reset; the 257th wraps seq to 0
        for (int f = 0; f < 255; f++) begin
            start_frame($urandom, hdr);
            collect(0, 1'b0, 1'b0, cyc);
        end
        check("pre_wrap_seq", 32'(model_seq), 32'd0);
        start_frame($urandom, hdr);
        check("hdr_wrap", hdr, 32'hCAFE_0022);
        collect(0, 1'b0, 1'b0, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
